dsigmf: RTL and testbench

Backward-pass companion to the forward sigmoid unit in the LSTM datapath. Accepts a stored forward activation `a` and an incoming error term `e`, and returns the back-propagated error `e * a * (1 - a)`. It uses the closed-form derivative of the sigmoid evaluated at its own output. It is a 3-stage pipeline with valid/ready handshakes on both sides and sits between the activation buffer and the gate-delta accumulator.

---
 rtl/dsigmf.sv | 89 ++++++++
 tb/tb_dsigmf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dsigmf.sv
// Sigmoid backward pass: o = e * a * (1 - a), with a clamped to [0, 1.0].
// Three-stage pipeline (clamp, derivative, scale) with valid/ready on both sides.
module dsigmf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] e,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] o
);

  localparam logic signed [WIDTH-1:0] One = WIDTH'(1) << FRAC;

  logic                      v1_q, v2_q, v3_q;
  logic                      adv1, adv2, adv3;
  logic signed [WIDTH-1:0]   ac_d, am_d, d_d, o_d;
  logic signed [WIDTH-1:0]   ac_q, am_q, e1_q, d_q, e2_q, o_q;
  logic signed [2*WIDTH-1:0] p2, p3;
  logic                      unused_bits;

  // Ripple advance: an empty stage always loads, so bubbles collapse under stall.
  always_comb begin
    adv3 = out_ready || !v3_q;
    adv2 = adv3 || !v2_q;
    adv1 = adv2 || !v1_q;
  end

  assign in_ready  = adv1;
  assign out_valid = v3_q;
  assign o         = o_q;

  always_comb begin
    if (a[WIDTH-1]) begin
      ac_d = '0;
    end else if (a > One) begin
      ac_d = One;
    end else begin
      ac_d = a;
    end
    am_d = One - ac_d;
  end

  // Taking bits [FRAC +: WIDTH] of the signed product is the arithmetic shift by FRAC.
  always_comb begin
    p2          = $signed({{WIDTH{ac_q[WIDTH-1]}}, ac_q}) * $signed({{WIDTH{am_q[WIDTH-1]}}, am_q});
    d_d         = p2[FRAC +: WIDTH];
    p3          = $signed({{WIDTH{e2_q[WIDTH-1]}}, e2_q}) * $signed({{WIDTH{d_q[WIDTH-1]}}, d_q});
    o_d         = p3[FRAC +: WIDTH];
    unused_bits = ^{p2[FRAC-1:0], p2[2*WIDTH-1:FRAC+WIDTH],
                    p3[FRAC-1:0], p3[2*WIDTH-1:FRAC+WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      ac_q <= '0;
      am_q <= '0;
      e1_q <= '0;
      d_q  <= '0;
      e2_q <= '0;
      o_q  <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        ac_q <= ac_d;
        am_q <= am_d;
        e1_q <= e;
      end
      if (adv2) begin
        v2_q <= v1_q;
        d_q  <= d_d;
        e2_q <= e1_q;
      end
      if (adv3) begin
        v3_q <= v2_q;
        o_q  <= o_d;
      end
    end
  end

endmodule

// File: tb/tb_dsigmf.sv
// Scoreboard bench for dsigmf: expected results queued on input handshake,
// popped and compared on output handshake.
module tb_dsigmf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] e;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] o;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_o     = '0;

  dsigmf #(.WIDTH(32), .FRAC(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .e        (e),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o        (o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] ev);
    longint ac, am, d, p;
    if (av[31]) ac = 0;
    else if (av > 32'h0010_0000) ac = 64'sd1 << 20;
    else ac = longint'(av);
    am = (64'sd1 << 20) - ac;
    d  = (ac * am) >>> 20;
    p  = (longint'($signed(ev)) * d) >>> 20;
    return p[31:0];
  endfunction

  // One clock cycle: drive at negedge, evaluate the handshakes the next posedge will take.
  task automatic drive(input logic r, input logic iv, input logic [31:0] av,
                       input logic [31:0] ev, input logic ordy, input logic [31:0] expv,
                       output logic acc, output logic got);
    @(negedge clk);
    rst = r; in_valid = iv; a = av; e = ev; out_ready = ordy;
    #1;
    acc = iv && in_ready && !r;
    got = 1'b0;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_o", o, prev_o);
    end
    if (acc) exp_q.push_back(expv);
    if (out_valid && out_ready && !r) begin
      got = 1'b1;
      if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else check("o", o, exp_q.pop_front());
    end
    prev_stall = out_valid && !out_ready && !r;
    prev_o     = o;
  endtask

  task automatic idle(input logic ordy);
    logic acc, got;
    drive(1'b0, 1'b0, 32'h0, 32'h0, ordy, 32'h0, acc, got);
  endtask

  task automatic directed(input logic [31:0] av, input logic [31:0] ev, input logic [31:0] expv);
    logic acc, got;
    int n;
    drive(1'b0, 1'b1, av, ev, 1'b1, expv, acc, got);
    check("dir_accept", 32'(acc), 32'd1);
    n = 0;
    got = 1'b0;
    while (!got && n < 9) begin
      n++;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, acc, got);
    end
    check("latency", 32'(n), 32'd3);
  endtask

  function automatic logic [31:0] rand_a();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'h0010_0000 + $urandom_range(0, 32'h0001_0000);
      default: return $urandom_range(0, 32'h0010_0000);
    endcase
  endfunction

  initial begin
    logic acc, got;
    logic [31:0] ra, re;
    logic [31:0] bp_a[4], bp_e[4];
    int accepted, cyc, gots;

    rst = 1'b1; in_valid = 1'b0; a = '0; e = '0; out_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h0008_0000, 32'h0010_0000, 1'b0, 32'h0, acc, got);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, acc, got);
    idle(1'b1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o", o, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    directed(32'h0008_0000, 32'h0010_0000, 32'h0004_0000);
    directed(32'h0009_9999, 32'h0010_0000, 32'h0003_D70A);
    directed(32'h0009_9999, 32'hFFF0_0000, 32'hFFFC_28F6);
    directed(32'hFFF0_0000, 32'h1234_5678, 32'h0);
    directed(32'h0020_0000, 32'h0010_0000, 32'h0);
    directed(32'h0010_0000, 32'h0010_0000, 32'h0);

    // Back-to-back streaming.
    for (int i = 0; i < 16; i++) begin
      ra = rand_a(); re = $urandom();
      drive(1'b0, 1'b1, ra, re, 1'b1, model(ra, re), acc, got);
      check("stream_ready", 32'(in_ready), 32'd1);
      if (i >= 3) check("stream_out", 32'(got), 32'd1);
    end
    repeat (4) idle(1'b1);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: three fill the pipe, the fourth waits.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = rand_a(); bp_e[i] = $urandom();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, bp_a[i], bp_e[i], 1'b0, model(bp_a[i], bp_e[i]), acc, got);
      check("bp_accept", 32'(acc), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, bp_a[3], bp_e[3], 1'b0, model(bp_a[3], bp_e[3]), acc, got);
      check("bp_full", 32'(in_ready), 32'd0);
    end
    gots = 0;
    acc  = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      drive(1'b0, 1'b1, bp_a[3], bp_e[3], 1'b1, model(bp_a[3], bp_e[3]), acc, got);
      if (got) gots++;
    end
    check("bp_fourth_accept", 32'(acc), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, acc, got);
      if (got) gots++;
    end
    check("bp_drain_count", 32'(gots), 32'd4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Random valid/ready toggling; pending data held until accepted.
    accepted = 0;
    cyc = 0;
    ra = rand_a(); re = $urandom();
    while (accepted < 1000 && cyc < 20000) begin
      drive(1'b0, 1'($urandom_range(0, 1)), ra, re, 1'($urandom_range(0, 1)),
            model(ra, re), acc, got);
      cyc++;
      if (acc) begin
        accepted++;
        ra = rand_a(); re = $urandom();
      end
    end
    check("rand_accepted", 32'(accepted), 32'd1000);
    repeat (8) idle(1'b1);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three items in flight; an offered input in the reset cycle is dropped.
    for (int i = 0; i < 3; i++) begin
      ra = rand_a(); re = $urandom();
      drive(1'b0, 1'b1, ra, re, 1'b0, model(ra, re), acc, got);
    end
    drive(1'b1, 1'b1, 32'h0008_0000, 32'h0010_0000, 1'b0, 32'h0, acc, got);
    exp_q.delete();
    idle(1'b1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_o", o, 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) idle(1'b1);
    directed(32'h0008_0000, 32'hFFF0_0000, 32'hFFFC_0000);
    repeat (4) idle(1'b1);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
